// File: rtl/lsu_ctrl.sv
// Load/store control: execute result in, one data-memory transaction, result out to write-back.
// Optional misaligned-access trap compiled in with `define LSU_ALIGN_CHECK_EN.
module lsu_ctrl #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_exu_valid,
  output logic                 o_exu_ready,
  input  logic [CPU_WIDTH-1:0] i_exu_exres,
  input  logic [CPU_WIDTH-1:0] i_exu_rs2,
  input  logic [2:0]           i_exu_lsopt,
  input  logic                 i_exu_ldflag,
  input  logic                 i_exu_stflag,
  input  logic [REG_ADDRW-1:0] i_exu_rdid,
  input  logic                 i_exu_rdwen,
  output logic                 o_mem_req,
  input  logic                 i_mem_gnt,
  output logic                 o_mem_wen,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]           o_mem_wmask,
  input  logic                 i_mem_rvalid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_lsu_valid,
  input  logic                 i_wbu_ready,
  output logic [CPU_WIDTH-1:0] o_lsu_exres,
  output logic [CPU_WIDTH-1:0] o_lsu_lsres,
  output logic [REG_ADDRW-1:0] o_lsu_rdid,
  output logic                 o_lsu_rdwen,
  output logic                 o_lsu_ldflag,
  output logic                 o_lsu_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CPU_WIDTH-1:0] exres_q, exres_d;
  logic [CPU_WIDTH-1:0] rs2_q, rs2_d;
  logic [CPU_WIDTH-1:0] lsres_q, lsres_d;
  logic [2:0]           lsopt_q, lsopt_d;
  logic                 ld_q, ld_d;
  logic                 st_q, st_d;
  logic [REG_ADDRW-1:0] rdid_q, rdid_d;
  logic                 rdwen_q, rdwen_d;

  logic                 accept;
  logic                 in_req;
  logic [2:0]           off;
  logic [5:0]           bsh;
  logic [CPU_WIDTH-1:0] rsh;
  logic [CPU_WIDTH-1:0] ldext;
  logic [7:0]           mask;

`ifdef LSU_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic mis_in;

  always_comb begin
    mis_in = 1'b0;
    unique case (1'b1)
      (i_exu_lsopt[1:0] == 2'b01): mis_in = i_exu_exres[0];
      (i_exu_lsopt[1:0] == 2'b10): mis_in = |i_exu_exres[1:0];
      (i_exu_lsopt[1:0] == 2'b11): mis_in = |i_exu_exres[2:0];
      default:                     mis_in = 1'b0;
    endcase
  end

  assign o_lsu_misalign = mis_q;
`else
  assign o_lsu_misalign = 1'b0;
`endif

  assign o_exu_ready = (state_q == S_IDLE) ||
                       ((state_q == S_DONE) && i_wbu_ready);
  assign accept      = i_exu_valid && o_exu_ready;

  assign off = exres_q[2:0];
  assign bsh = {off, 3'b000};
  assign rsh = i_mem_rdata >> bsh;

  always_comb begin
    mask = 8'h00;
    unique case (1'b1)
      (lsopt_q[1:0] == 2'b00): mask = 8'h01 << off;
      (lsopt_q[1:0] == 2'b01): mask = 8'h03 << off;
      (lsopt_q[1:0] == 2'b10): mask = 8'h0F << off;
      default:                 mask = 8'hFF;
    endcase
  end

  always_comb begin
    ldext = rsh;
    case (lsopt_q)
      3'b000:  ldext = {{(CPU_WIDTH-8){rsh[7]}}, rsh[7:0]};
      3'b001:  ldext = {{(CPU_WIDTH-16){rsh[15]}}, rsh[15:0]};
      3'b010:  ldext = {{(CPU_WIDTH-32){rsh[31]}}, rsh[31:0]};
      3'b100:  ldext = {{(CPU_WIDTH-8){1'b0}}, rsh[7:0]};
      3'b101:  ldext = {{(CPU_WIDTH-16){1'b0}}, rsh[15:0]};
      3'b110:  ldext = {{(CPU_WIDTH-32){1'b0}}, rsh[31:0]};
      default: ldext = rsh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    exres_d = exres_q;
    rs2_d   = rs2_q;
    lsres_d = lsres_q;
    lsopt_d = lsopt_q;
    ld_d    = ld_q;
    st_d    = st_q;
    rdid_d  = rdid_q;
    rdwen_d = rdwen_q;
`ifdef LSU_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    if (accept) begin
      exres_d = i_exu_exres;
      rs2_d   = i_exu_rs2;
      lsopt_d = i_exu_lsopt;
      ld_d    = i_exu_ldflag;
      st_d    = i_exu_stflag;
      rdid_d  = i_exu_rdid;
      rdwen_d = i_exu_rdwen;
      lsres_d = '0;
      state_d = (i_exu_ldflag || i_exu_stflag) ? S_REQ : S_DONE;
`ifdef LSU_ALIGN_CHECK_EN
      mis_d   = 1'b0;
      // trapped ops skip the bus and never write the register file
      if ((i_exu_ldflag || i_exu_stflag) && mis_in) begin
        state_d = S_DONE;
        mis_d   = 1'b1;
        rdwen_d = 1'b0;
      end
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (i_mem_gnt) state_d = st_q ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            lsres_d = ldext;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (i_wbu_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      exres_q <= '0;
      rs2_q   <= '0;
      lsres_q <= '0;
      lsopt_q <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      rdid_q  <= '0;
      rdwen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exres_q <= exres_d;
      rs2_q   <= rs2_d;
      lsres_q <= lsres_d;
      lsopt_q <= lsopt_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      rdid_q  <= rdid_d;
      rdwen_q <= rdwen_d;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
`endif

  assign in_req      = (state_q == S_REQ);
  assign o_mem_req   = in_req;
  assign o_mem_wen   = in_req && st_q;
  assign o_mem_addr  = in_req ? {exres_q[CPU_WIDTH-1:3], 3'b000} : '0;
  assign o_mem_wdata = in_req ? (rs2_q << bsh) : '0;
  assign o_mem_wmask = in_req ? mask : 8'h00;

  assign o_lsu_valid  = (state_q == S_DONE);
  assign o_lsu_exres  = exres_q;
  assign o_lsu_lsres  = lsres_q;
  assign o_lsu_rdid   = rdid_q;
  assign o_lsu_rdwen  = rdwen_q;
  assign o_lsu_ldflag = ld_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table of memory ops plus hand sequences.
// Expected write-back results go through a queue and are popped when o_lsu_valid is due.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exu_valid = 1'b0;
  logic        exu_ready;
  logic [63:0] exu_exres = '0;
  logic [63:0] exu_rs2 = '0;
  logic [2:0]  exu_lsopt = '0;
  logic        exu_ld = 1'b0;
  logic        exu_st = 1'b0;
  logic [4:0]  exu_rdid = '0;
  logic        exu_rdwen = 1'b0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        lsu_valid;
  logic        wbu_ready = 1'b1;
  logic [63:0] lsu_exres;
  logic [63:0] lsu_lsres;
  logic [4:0]  lsu_rdid;
  logic        lsu_rdwen;
  logic        lsu_ldflag;
  logic        lsu_mis;

  lsu_ctrl #(.CPU_WIDTH(64), .REG_ADDRW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_exu_valid(exu_valid), .o_exu_ready(exu_ready),
    .i_exu_exres(exu_exres), .i_exu_rs2(exu_rs2),
    .i_exu_lsopt(exu_lsopt), .i_exu_ldflag(exu_ld),
    .i_exu_stflag(exu_st), .i_exu_rdid(exu_rdid),
    .i_exu_rdwen(exu_rdwen),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt),
    .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_lsu_valid(lsu_valid), .i_wbu_ready(wbu_ready),
    .o_lsu_exres(lsu_exres), .o_lsu_lsres(lsu_lsres),
    .o_lsu_rdid(lsu_rdid), .o_lsu_rdwen(lsu_rdwen),
    .o_lsu_ldflag(lsu_ldflag), .o_lsu_misalign(lsu_mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        ld;
    logic        st;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [63:0] rdata;
    int          gd;
    int          rd;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic [63:0] e_lsres;
    logic [7:0]  e_mask;
  } vec_t;

  typedef struct {
    logic [63:0] exres;
    logic [63:0] lsres;
    logic [4:0]  rdid;
    logic        rdwen;
    logic        ld;
    logic        mis;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] ex, input logic [63:0] ls,
                      input logic [4:0] rd, input logic we,
                      input logic ld, input logic mis);
    exp_t e;
    e.exres = ex; e.lsres = ls; e.rdid = rd;
    e.rdwen = we; e.ld = ld; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, ".valid"}, lsu_valid, 1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.sb: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".exres"}, lsu_exres, e.exres);
      chk({tag, ".lsres"}, lsu_lsres, e.lsres);
      chk({tag, ".rdid"}, lsu_rdid, e.rdid);
      chk({tag, ".rdwen"}, lsu_rdwen, e.rdwen);
      chk({tag, ".ldflag"}, lsu_ldflag, e.ld);
      chk({tag, ".mis"}, lsu_mis, e.mis);
    end
  endtask

  task automatic drive_op(input logic [2:0] op, input logic ld,
                          input logic st, input logic [63:0] ex,
                          input logic [63:0] rs2, input logic [4:0] rd,
                          input logic we);
    exu_valid = 1'b1;
    exu_lsopt = op;
    exu_ld    = ld;
    exu_st    = st;
    exu_exres = ex;
    exu_rs2   = rs2;
    exu_rdid  = rd;
    exu_rdwen = we;
  endtask

  task automatic check_req(input string tag, input vec_t v);
    chk({tag, ".req"}, mem_req, 1);
    chk({tag, ".wen"}, mem_wen, v.st);
    chk({tag, ".addr"}, mem_addr, v.e_addr);
    if (v.st) begin
      chk({tag, ".wdata"}, mem_wdata, v.e_wdata);
      chk({tag, ".wmask"}, mem_wmask, v.e_mask);
    end
  endtask

  task automatic run_op(input int i);
    vec_t  v;
    string tag;
    v   = vt[i];
    tag = $sformatf("v%0d", i);
    step();
    drive_op(v.op, v.ld, v.st, v.addr, v.rs2, 5'(i + 1), v.ld);
    sample();
    chk({tag, ".ready"}, exu_ready, 1);
    push(v.addr, v.ld ? v.e_lsres : 64'd0, 5'(i + 1), v.ld, v.ld, 1'b0);
    step();
    exu_valid = 1'b0;
    mem_gnt = (v.gd == 0);
    sample();
    check_req(tag, v);
    for (int k = 1; k <= v.gd; k++) begin
      step();
      mem_gnt = (k == v.gd);
      sample();
      check_req(tag, v);
    end
    step();
    mem_gnt = 1'b0;
    if (!v.ld) begin
      sample();
      check_done(tag);
    end else begin
      for (int j = 1; j <= v.rd; j++) begin
        if (j > 1) step();
        mem_rvalid = (j == v.rd);
        mem_rdata  = (j == v.rd) ? v.rdata : {$urandom, $urandom};
        sample();
        chk({tag, ".early"}, {lsu_valid, mem_req}, 2'b00);
      end
      step();
      mem_rvalid = 1'b0;
      sample();
      check_done(tag);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{3'b000, 0, 1, 64'h1003, 64'hAB, 64'h0, 2, 0,
                   64'h1000, 64'hAB00_0000, 64'h0, 8'h08});
    vt.push_back('{3'b001, 1, 0, 64'h2002, 64'h0, 64'h8001_0000, 0, 3,
                   64'h2000, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 8'h0});
    vt.push_back('{3'b110, 1, 0, 64'h2000, 64'h0, 64'h8001_0000, 1, 1,
                   64'h2000, 64'h0, 64'h0000_0000_8001_0000, 8'h0});
    vt.push_back('{3'b010, 1, 0, 64'h2004, 64'h0,
                   64'h8765_4321_0000_0000, 0, 1,
                   64'h2000, 64'h0, 64'hFFFF_FFFF_8765_4321, 8'h0});
    vt.push_back('{3'b000, 1, 0, 64'h3007, 64'h0,
                   64'h80FF_0000_0000_0000, 1, 2,
                   64'h3000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 8'h0});
    vt.push_back('{3'b100, 1, 0, 64'h3006, 64'h0,
                   64'h80FF_0000_0000_0000, 0, 1,
                   64'h3000, 64'h0, 64'h0000_0000_0000_00FF, 8'h0});
    vt.push_back('{3'b011, 1, 0, 64'h4008, 64'h0,
                   64'h0123_4567_89AB_CDEF, 2, 1,
                   64'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 8'h0});
    vt.push_back('{3'b001, 0, 1, 64'h1006, 64'h1234, 64'h0, 0, 0,
                   64'h1000, 64'h1234_0000_0000_0000, 64'h0, 8'hC0});
    vt.push_back('{3'b010, 0, 1, 64'h1004, 64'hDEAD_BEEF, 64'h0, 1, 0,
                   64'h1000, 64'hDEAD_BEEF_0000_0000, 64'h0, 8'hF0});
    vt.push_back('{3'b011, 0, 1, 64'h1008, 64'h1122_3344_5566_7788,
                   64'h0, 0, 0, 64'h1008, 64'h1122_3344_5566_7788,
                   64'h0, 8'hFF});
    vt.push_back('{3'b101, 1, 0, 64'h2002, 64'h0, 64'h8001_0000, 0, 1,
                   64'h2000, 64'h0, 64'h0000_0000_0000_8001, 8'h0});
`ifndef LSU_ALIGN_CHECK_EN
    vt.push_back('{3'b010, 0, 1, 64'h1006, 64'hDEAD_BEEF, 64'h0, 0, 0,
                   64'h1000, 64'hBEEF_0000_0000_0000, 64'h0, 8'hC0});
    vt.push_back('{3'b010, 1, 0, 64'h2002, 64'h0, 64'h8001_0000, 0, 1,
                   64'h2000, 64'h0, 64'h0000_0000_0000_8001, 8'h0});
`endif

    repeat (3) step();
    rst_n = 1'b1;
    sample();
    chk("rst.ready", exu_ready, 1);
    chk("rst.memreq", {mem_req, mem_wen, mem_wmask}, 0);
    chk("rst.memaddr", mem_addr, 0);
    chk("rst.memwdata", mem_wdata, 0);
    chk("rst.lsuvalid", {lsu_valid, lsu_rdwen, lsu_ldflag, lsu_mis}, 0);
    chk("rst.exres", lsu_exres, 0);
    chk("rst.lsres", lsu_lsres, 0);
    chk("rst.rdid", lsu_rdid, 0);

    // reset in the middle of a request abandons it
    step();
    drive_op(3'b011, 1'b0, 1'b1, 64'h5000, 64'h77, 5'd3, 1'b0);
    sample();
    step();
    exu_valid = 1'b0;
    sample();
    chk("mid.req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.rstreq", mem_req, 0);
    chk("mid.rstvalid", lsu_valid, 0);
    chk("mid.rstready", exu_ready, 1);
    step();
    rst_n = 1'b1;

    // back-to-back non-memory ops
    step();
    drive_op(3'b000, 1'b0, 1'b0, 64'h11, 64'h0, 5'd1, 1'b1);
    sample();
    push(64'h11, 0, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    drive_op(3'b000, 1'b0, 1'b0, 64'h22, 64'h0, 5'd2, 1'b1);
    sample();
    check_done("b2b0");
    push(64'h22, 0, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    drive_op(3'b000, 1'b0, 1'b0, 64'h33, 64'h0, 5'd3, 1'b1);
    sample();
    check_done("b2b1");
    push(64'h33, 0, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    exu_valid = 1'b0;
    sample();
    check_done("b2b2");
    step();
    sample();
    chk("b2b.idle", lsu_valid, 0);

    foreach (vt[i]) run_op(i);

    // backpressure with a second op waiting
    step();
    drive_op(3'b000, 1'b0, 1'b0, 64'h55, 64'h0, 5'd7, 1'b1);
    sample();
    push(64'h55, 0, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      wbu_ready = 1'b0;
      drive_op(3'b000, 1'b0, 1'b0, 64'h66, 64'h0, 5'd8, 1'b1);
      sample();
      chk($sformatf("bp%0d.valid", c), lsu_valid, 1);
      chk($sformatf("bp%0d.exres", c), lsu_exres, sb[0].exres);
      chk($sformatf("bp%0d.rdid", c), lsu_rdid, sb[0].rdid);
      chk($sformatf("bp%0d.ready", c), exu_ready, 0);
    end
    step();
    wbu_ready = 1'b1;
    sample();
    chk("bp.release", exu_ready, 1);
    check_done("bp.first");
    push(64'h66, 0, 5'd8, 1'b1, 1'b0, 1'b0);
    step();
    exu_valid = 1'b0;
    sample();
    check_done("bp.second");

`ifdef LSU_ALIGN_CHECK_EN
    step();
    drive_op(3'b010, 1'b1, 1'b0, 64'h2002, 64'h0, 5'd9, 1'b1);
    sample();
    push(64'h2002, 0, 5'd9, 1'b0, 1'b1, 1'b1);
    step();
    exu_valid = 1'b0;
    sample();
    chk("mis.req", mem_req, 0);
    check_done("mis");
`endif

    step();
    sample();
    chk("end.idle", {lsu_valid, mem_req}, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
